// File: rtl/mips_defs.sv
// Shared encodings for the MIPS writeback path: result sources, load widths,
// writeback FSM states and small decode helpers.
package mips_defs;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_RSVD = 2'b11;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_LOAD = 2'b01,
    ST_COMMIT    = 2'b10
  } wb_state_e;

  // Result for non-load instructions; the reserved source behaves as ALU.
  function automatic logic [31:0] wb_select(input logic [1:0] sel,
                                            input logic [31:0] alu_res,
                                            input logic [31:0] link_val);
    logic [31:0] res;
    case (sel)
      WB_LINK: res = link_val;
      default: res = alu_res;
    endcase
    return res;
  endfunction

  // Register 0 is hardwired, so a write to it is never issued.
  function automatic logic reg_we(input logic reg_write, input logic [4:0] dest);
    return reg_write && (dest != REG_ZERO);
  endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian load alignment: selects the addressed byte/halfword from the
// returned word and sign- or zero-extends it.
module load_align
  import mips_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  load_type,
  input  logic [1:0]  byte_off,
  output logic [31:0] result
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Lane selection; byte lane 0 is the most significant byte.
  always_comb begin
    half_s = 16'h0000;
    byte_s = 8'h00;
    if (byte_off[1]) begin
      half_s = rdata[15:0];
    end else begin
      half_s = rdata[31:16];
    end
    case (byte_off)
      2'd0:    byte_s = rdata[31:24];
      2'd1:    byte_s = rdata[23:16];
      2'd2:    byte_s = rdata[15:8];
      2'd3:    byte_s = rdata[7:0];
      default: byte_s = rdata[31:24];
    endcase
  end

  // Extension by load type; unknown types pass the word through like lw.
  always_comb begin
    result = rdata;
    case (load_type)
      LT_LH:   result = {{16{half_s[15]}}, half_s};
      LT_LHU:  result = {16'h0000, half_s};
      LT_LB:   result = {{24{byte_s[7]}}, byte_s};
      LT_LBU:  result = {24'h000000, byte_s};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// MIPS writeback stage: sole owner of the register-file write port, with a
// forwarding mirror, retired-instruction counter and sticky load timeout flag.
module reg_writeback
  import mips_defs::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        memValid,
  output logic        memReady,
  input  logic        memRegWrite,
  input  logic [4:0]  memWriteReg,
  input  logic [1:0]  memWbSel,
  input  logic [31:0] memAluRes,
  input  logic [31:0] memPcPlus8,
  input  logic [2:0]  memLoadType,
  input  logic [1:0]  memByteOff,
  input  logic        dmemRvalid,
  input  logic [31:0] dmemRdata,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        fwdValid,
  output logic [4:0]  fwdReg,
  output logic [31:0] fwdData,
  output logic [31:0] instRetired,
  output logic        loadErr
);

  localparam logic [31:0] WAIT_LAST = 32'(LOAD_TIMEOUT - 1);

  wb_state_e   state_r, next_s;
  logic        mem_ready_s, accept_s, is_load_s, load_done_s, timeout_s;
  logic [31:0] aligned_s;
  logic [31:0] wait_cnt_r;
  logic        pend_we_r;
  logic [4:0]  pend_reg_r;
  logic [2:0]  pend_type_r;
  logic [1:0]  pend_off_r;
  logic        reg_write_r;
  logic [4:0]  write_reg_r;
  logic [31:0] write_data_r;
  logic [31:0] inst_retired_r;
  logic        load_err_r;

  assign is_load_s = (memWbSel == WB_LOAD);

  load_align u_load_align (
    .rdata     (dmemRdata),
    .load_type (pend_type_r),
    .byte_off  (pend_off_r),
    .result    (aligned_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode; COMMIT accepts exactly like IDLE so non-loads stream.
  always_comb begin
    next_s      = state_r;
    mem_ready_s = 1'b0;
    accept_s    = 1'b0;
    load_done_s = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_COMMIT: begin
        mem_ready_s = 1'b1;
        if (memValid) begin
          accept_s = 1'b1;
          if (is_load_s) begin
            next_s = ST_WAIT_LOAD;
          end else begin
            next_s = ST_COMMIT;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_WAIT_LOAD: begin
        if (dmemRvalid) begin
          load_done_s = 1'b1;
          next_s      = ST_COMMIT;
        end else if (wait_cnt_r == WAIT_LAST) begin
          timeout_s = 1'b1;
          next_s    = ST_IDLE;
        end else begin
          next_s = ST_WAIT_LOAD;
        end
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // Pending-load capture, write-port registers, counters and error flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pend_we_r      <= 1'b0;
      pend_reg_r     <= 5'd0;
      pend_type_r    <= 3'd0;
      pend_off_r     <= 2'd0;
      wait_cnt_r     <= 32'd0;
      reg_write_r    <= 1'b0;
      write_reg_r    <= 5'd0;
      write_data_r   <= 32'd0;
      inst_retired_r <= 32'd0;
      load_err_r     <= 1'b0;
    end else begin
      reg_write_r <= 1'b0;
      if (accept_s && !is_load_s) begin
        reg_write_r    <= reg_we(memRegWrite, memWriteReg);
        write_reg_r    <= memWriteReg;
        write_data_r   <= wb_select(memWbSel, memAluRes, memPcPlus8);
        inst_retired_r <= inst_retired_r + 32'd1;
      end else if (accept_s) begin
        pend_we_r   <= reg_we(memRegWrite, memWriteReg);
        pend_reg_r  <= memWriteReg;
        pend_type_r <= memLoadType;
        pend_off_r  <= memByteOff;
      end else if (load_done_s) begin
        reg_write_r    <= pend_we_r;
        write_reg_r    <= pend_reg_r;
        write_data_r   <= aligned_s;
        inst_retired_r <= inst_retired_r + 32'd1;
      end else if (timeout_s) begin
        load_err_r <= 1'b1;
      end
      // Wait count is 0 in the first WAIT_LOAD cycle.
      if (accept_s) begin
        wait_cnt_r <= 32'd0;
      end else if (state_r == ST_WAIT_LOAD) begin
        wait_cnt_r <= wait_cnt_r + 32'd1;
      end
    end
  end

  assign memReady    = mem_ready_s;
  assign regWrite    = reg_write_r;
  assign writeReg    = write_reg_r;
  assign writeData   = write_data_r;
  assign fwdValid    = reg_write_r;
  assign fwdReg      = write_reg_r;
  assign fwdData     = write_data_r;
  assign instRetired = inst_retired_r;
  assign loadErr     = load_err_r;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback: ALU/link commits, aligned
// loads, back-to-back streaming, load timeout and reset during a load.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        memValid = 1'b0;
  logic        memReady;
  logic        memRegWrite = 1'b0;
  logic [4:0]  memWriteReg = 5'd0;
  logic [1:0]  memWbSel = 2'b00;
  logic [31:0] memAluRes = 32'd0;
  logic [31:0] memPcPlus8 = 32'd0;
  logic [2:0]  memLoadType = 3'd0;
  logic [1:0]  memByteOff = 2'd0;
  logic        dmemRvalid = 1'b0;
  logic [31:0] dmemRdata = 32'd0;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        fwdValid;
  logic [4:0]  fwdReg;
  logic [31:0] fwdData;
  logic [31:0] instRetired;
  logic        loadErr;

  int n_checks = 0;
  int n_fail = 0;

  reg_writeback #(.LOAD_TIMEOUT(16)) dut (
    .clk(clk), .rstN(rstN), .memValid(memValid), .memReady(memReady),
    .memRegWrite(memRegWrite), .memWriteReg(memWriteReg), .memWbSel(memWbSel),
    .memAluRes(memAluRes), .memPcPlus8(memPcPlus8), .memLoadType(memLoadType),
    .memByteOff(memByteOff), .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .fwdValid(fwdValid), .fwdReg(fwdReg), .fwdData(fwdData),
    .instRetired(instRetired), .loadErr(loadErr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    memValid = 1'b0;
    dmemRvalid = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic drive_op(input logic [4:0] rd, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] link);
    memValid = 1'b1; memRegWrite = 1'b1; memWriteReg = rd; memWbSel = sel;
    memAluRes = alu; memPcPlus8 = link; memLoadType = 3'd0; memByteOff = 2'd0;
  endtask

  // Accept a load, return rvalid k cycles later; ends in the commit cycle.
  task automatic run_load(input logic [2:0] lt, input logic [1:0] off, input logic [4:0] rd,
                          input logic [31:0] rdata, input int k);
    memValid = 1'b1; memRegWrite = 1'b1; memWriteReg = rd; memWbSel = 2'b01;
    memLoadType = lt; memByteOff = off; memAluRes = {30'd0, off};
    tick();
    memValid = 1'b0;
    for (int i = 1; i < k; i++) tick();
    dmemRvalid = 1'b1; dmemRdata = rdata;
    tick();
    dmemRvalid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rstN = 1'b0;
    #1;
    n_checks++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regWrite: got %b want 0", regWrite); end
    n_checks++; if (writeReg !== 5'd0) begin n_fail++; $display("FAIL reset_writeReg: got %h want 0", writeReg); end
    n_checks++; if (writeData !== 32'd0) begin n_fail++; $display("FAIL reset_writeData: got %h want 0", writeData); end
    n_checks++; if ({fwdValid, fwdReg, fwdData} !== 38'd0) begin n_fail++; $display("FAIL reset_fwd: got %b/%h/%h want 0", fwdValid, fwdReg, fwdData); end
    n_checks++; if (instRetired !== 32'd0) begin n_fail++; $display("FAIL reset_instRetired: got %h want 0", instRetired); end
    n_checks++; if (loadErr !== 1'b0) begin n_fail++; $display("FAIL reset_loadErr: got %b want 0", loadErr); end
    tick();
    tick();
    rstN = 1'b1;
    tick();
    n_checks++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL reset_memReady: got %b want 1", memReady); end
  endtask

  task automatic test_alu();
    drive_op(5'd5, 2'b00, 32'h1234_5678, 32'hAAAA_0000);
    n_checks++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b want 1", memReady); end
    tick();
    memValid = 1'b0;
    n_checks++; if (regWrite !== 1'b1 || writeReg !== 5'd5) begin n_fail++; $display("FAIL alu_write: got %b/%h want 1/05", regWrite, writeReg); end
    n_checks++; if (writeData !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_data: got %h want 12345678", writeData); end
    n_checks++; if (fwdValid !== 1'b1 || fwdReg !== 5'd5 || fwdData !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_fwd: got %b/%h/%h want 1/05/12345678", fwdValid, fwdReg, fwdData); end
    n_checks++; if (instRetired !== 32'd1) begin n_fail++; $display("FAIL alu_retired: got %0d want 1", instRetired); end
    tick();
    n_checks++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL alu_single_pulse: got %b want 0", regWrite); end
  endtask

  task automatic test_lb();
    memValid = 1'b1; memRegWrite = 1'b1; memWriteReg = 5'd7; memWbSel = 2'b01;
    memLoadType = 3'b011; memByteOff = 2'd2; memAluRes = 32'h1000_0002;
    tick();
    memValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (memReady !== 1'b0 || regWrite !== 1'b0) begin n_fail++; $display("FAIL lb_wait_%0d: ready/regWrite got %b/%b want 0/0", i, memReady, regWrite); end
      if (i == 2) begin dmemRvalid = 1'b1; dmemRdata = 32'h0011_8033; end
      tick();
    end
    dmemRvalid = 1'b0;
    n_checks++; if (regWrite !== 1'b1 || writeReg !== 5'd7) begin n_fail++; $display("FAIL lb_write: got %b/%h want 1/07", regWrite, writeReg); end
    n_checks++; if (writeData !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", writeData); end
    n_checks++; if (instRetired !== 32'd2) begin n_fail++; $display("FAIL lb_retired: got %0d want 2", instRetired); end
    tick();
    n_checks++; if (regWrite !== 1'b0 || memReady !== 1'b1) begin n_fail++; $display("FAIL lb_idle: regWrite/ready got %b/%b want 0/1", regWrite, memReady); end
  endtask

  task automatic test_loads_and_link();
    run_load(3'b010, 2'd0, 5'd8, 32'hBEEF_0000, 1);
    n_checks++; if (regWrite !== 1'b1 || writeData !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_data: got %b/%h want 1/0000beef", regWrite, writeData); end
    n_checks++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL commit_ready: got %b want 1", memReady); end
    run_load(3'b000, 2'd0, 5'd9, 32'hDEAD_BEEF, 2);
    n_checks++; if (regWrite !== 1'b1 || writeReg !== 5'd9 || writeData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %b/%h/%h want 1/09/deadbeef", regWrite, writeReg, writeData); end
    run_load(3'b001, 2'd2, 5'd10, 32'h1234_8001, 1);
    n_checks++; if (writeData !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_low_data: got %h want ffff8001", writeData); end
    run_load(3'b100, 2'd1, 5'd11, 32'h12F4_5678, 1);
    n_checks++; if (writeData !== 32'h0000_00F4) begin n_fail++; $display("FAIL lbu_data: got %h want 000000f4", writeData); end
    drive_op(5'd31, 2'b10, 32'h0000_1111, 32'h0040_0010);
    tick();
    memValid = 1'b0;
    n_checks++; if (regWrite !== 1'b1 || writeReg !== 5'd31 || writeData !== 32'h0040_0010) begin n_fail++; $display("FAIL link_data: got %b/%h/%h want 1/1f/00400010", regWrite, writeReg, writeData); end
    n_checks++; if (instRetired !== 32'd7) begin n_fail++; $display("FAIL loads_retired: got %0d want 7", instRetired); end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    do_reset();
    pulses = 0;
    drive_op(5'd1, 2'b00, 32'h0000_0011, 32'd0);
    tick();
    pulses += int'(regWrite);
    n_checks++; if (regWrite !== 1'b1 || writeData !== 32'h0000_0011 || memReady !== 1'b1) begin n_fail++; $display("FAIL b2b_op1: got %b/%h ready %b want 1/00000011 ready 1", regWrite, writeData, memReady); end
    drive_op(5'd0, 2'b00, 32'h0000_0022, 32'd0);
    tick();
    pulses += int'(regWrite);
    n_checks++; if (regWrite !== 1'b0 || memReady !== 1'b1) begin n_fail++; $display("FAIL b2b_r0: regWrite/ready got %b/%b want 0/1", regWrite, memReady); end
    drive_op(5'd3, 2'b11, 32'h0000_0033, 32'hFFFF_FFFF);
    tick();
    pulses += int'(regWrite);
    n_checks++; if (regWrite !== 1'b1 || writeReg !== 5'd3 || writeData !== 32'h0000_0033) begin n_fail++; $display("FAIL b2b_op3: got %b/%h/%h want 1/03/00000033", regWrite, writeReg, writeData); end
    drive_op(5'd4, 2'b00, 32'h0000_0044, 32'd0);
    tick();
    memValid = 1'b0;
    pulses += int'(regWrite);
    n_checks++; if (regWrite !== 1'b1 || writeReg !== 5'd4 || writeData !== 32'h0000_0044) begin n_fail++; $display("FAIL b2b_op4: got %b/%h/%h want 1/04/00000044", regWrite, writeReg, writeData); end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    n_checks++; if (instRetired !== 32'd4) begin n_fail++; $display("FAIL b2b_retired: got %0d want 4", instRetired); end
    tick();
  endtask

  task automatic test_rvalid_at_limit();
    run_load(3'b000, 2'd0, 5'd12, 32'hCAFE_F00D, 16);
    n_checks++; if (regWrite !== 1'b1 || writeData !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL limit_write: got %b/%h want 1/cafef00d", regWrite, writeData); end
    n_checks++; if (loadErr !== 1'b0) begin n_fail++; $display("FAIL limit_loadErr: got %b want 0", loadErr); end
    n_checks++; if (instRetired !== 32'd5) begin n_fail++; $display("FAIL limit_retired: got %0d want 5", instRetired); end
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    memValid = 1'b1; memRegWrite = 1'b1; memWriteReg = 5'd13; memWbSel = 2'b01;
    memLoadType = 3'b000; memByteOff = 2'd0;
    tick();
    memValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (memReady !== 1'b0 || regWrite !== 1'b0 || loadErr !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL timeout_wait: %0d bad wait cycles, want 0", bad); end
    n_checks++; if (loadErr !== 1'b1 || memReady !== 1'b1) begin n_fail++; $display("FAIL timeout_exit: loadErr/ready got %b/%b want 1/1", loadErr, memReady); end
    n_checks++; if (regWrite !== 1'b0 || instRetired !== 32'd5) begin n_fail++; $display("FAIL timeout_nowrite: got %b retired %0d want 0 retired 5", regWrite, instRetired); end
    dmemRvalid = 1'b1; dmemRdata = 32'h7777_7777;
    tick();
    dmemRvalid = 1'b0;
    n_checks++; if (regWrite !== 1'b0 || instRetired !== 32'd5) begin n_fail++; $display("FAIL late_rvalid: got %b retired %0d want 0 retired 5", regWrite, instRetired); end
    drive_op(5'd14, 2'b00, 32'h0000_ABCD, 32'd0);
    tick();
    memValid = 1'b0;
    n_checks++; if (regWrite !== 1'b1 || writeData !== 32'h0000_ABCD || loadErr !== 1'b1) begin n_fail++; $display("FAIL after_timeout: got %b/%h err %b want 1/0000abcd err 1", regWrite, writeData, loadErr); end
    tick();
  endtask

  task automatic test_reset_mid_load();
    memValid = 1'b1; memRegWrite = 1'b1; memWriteReg = 5'd15; memWbSel = 2'b01;
    memLoadType = 3'b000; memByteOff = 2'd0;
    tick();
    memValid = 1'b0;
    tick();
    rstN = 1'b0;
    #1;
    n_checks++; if ({regWrite, writeReg, writeData, fwdValid, fwdReg, fwdData, instRetired, loadErr} !== 109'd0) begin n_fail++; $display("FAIL midload_reset: outputs %b/%h/%h/%h/%b not all zero", regWrite, writeReg, writeData, instRetired, loadErr); end
    tick();
    rstN = 1'b1;
    n_checks++; if (memReady !== 1'b1) begin n_fail++; $display("FAIL midload_ready: got %b want 1", memReady); end
    dmemRvalid = 1'b1; dmemRdata = 32'h5555_AAAA;
    tick();
    dmemRvalid = 1'b0;
    tick();
    n_checks++; if (regWrite !== 1'b0 || instRetired !== 32'd0 || writeData !== 32'd0) begin n_fail++; $display("FAIL midload_abandon: got %b retired %0d data %h want 0/0/0", regWrite, instRetired, writeData); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_loads_and_link();
    test_back_to_back();
    test_rvalid_at_limit();
    test_timeout();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
